// File: rtl/atm_pager_pkg.sv
// Shared constants, state type and readback format for the ATM quad pager.
package atm_pager_pkg;

  // Width of the page bits addressed by a plain xxF7 write
  localparam int unsigned BASE_W = 8;
  localparam int unsigned CNT_W  = 4;

  // Reset page numbers (low 8 bits); ROM maps keep their upper bits at ones
  localparam logic [7:0] PG_BAS128 = 8'hFE;
  localparam logic [7:0] PG_BAS48  = 8'hFC;
  localparam logic [7:0] PG_RAM5   = 8'h05;
  localparam logic [7:0] PG_RAM2   = 8'h02;
  localparam logic [7:0] PG_RAM0   = 8'h00;

  // za[13:8] of the TR-DOS entry region in ROM window 0
  localparam logic [5:0] DOS_HI_DEF = 6'h3D;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } stall_state_e;

  // xxF7 readback byte: {dos7ffd, ramnrom, ~page[5:0]}
  typedef struct packed {
    logic       dos7ffd;
    logic       ramnrom;
    logic [5:0] pg_n;
  } rd_fmt_t;

endpackage

// File: rtl/atm_stall_fsm.sv
// Z80 clock-stall sequencer: holds zclk_stall for STALL_LEN fclk cycles after
// each trigger; a trigger during a stall restarts the count.
// Ports: fclk, arst_n (async, active low), trig (1-fclk strobe), zclk_stall.
module atm_stall_fsm
  import atm_pager_pkg::*;
#(
  parameter int unsigned STALL_LEN = 4
) (
  input  logic fclk,
  input  logic arst_n,
  input  logic trig,
  output logic zclk_stall
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STALL_LEN - 1);

  stall_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, counter and registered stall output
  always_ff @(posedge fclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      zclk_stall <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      zclk_stall <= (state_d == ST_STALL);
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_STALL;
          cnt_d   = RELOAD;
        end
      end
      ST_STALL: begin
        if (trig) begin
          cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/atm_pager_quad.sv
// Four-window ATM pager: per-window/per-map page registers written via xxF7,
// registered page/ROM lookup for za[15:14], DOS entry/exit strobes from M1
// fetches, clock stall on DOS entry, and xxF7 readback.
// Ports: fclk/arst_n; zpos/zneg/za/zd/mreq_n/m1_n from the Z80 side;
// pager_off/map_sel/p7_page/ram0_0/p1m_on/dos from the port decoder;
// f7_wr/hi_wr write strobes; rd_win/rd_data readback; page/romnram to the
// arbiter; dos_turn_on/dos_turn_off strobes; zclk_stall clock hold.
module atm_pager_quad
  import atm_pager_pkg::*;
#(
  parameter int unsigned PAGE_W    = 8,
  parameter int unsigned STALL_LEN = 4,
  parameter logic [5:0]  DOS_HI    = DOS_HI_DEF
) (
  input  logic              fclk,
  input  logic              arst_n,
  input  logic              zpos,
  input  logic              zneg,
  input  logic [15:0]       za,
  input  logic [7:0]        zd,
  input  logic              mreq_n,
  input  logic              m1_n,
  input  logic              pager_off,
  input  logic              map_sel,
  input  logic [5:0]        p7_page,
  input  logic              ram0_0,
  input  logic              p1m_on,
  input  logic              f7_wr,
  input  logic              hi_wr,
  input  logic              dos,
  input  logic [1:0]        rd_win,
  output logic [7:0]        rd_data,
  output logic [PAGE_W-1:0] page,
  output logic              romnram,
  output logic              dos_turn_on,
  output logic              dos_turn_off,
  output logic              zclk_stall
);

  localparam logic [PAGE_W-1:0] LO_MASK = PAGE_W'(8'hFF);
  localparam logic [PAGE_W-1:0] HI_MASK = ~LO_MASK;
  localparam logic [PAGE_W-1:0] KEEP6   = ~PAGE_W'(6'h3F);
  localparam logic [PAGE_W-1:0] KEEP3   = ~PAGE_W'(3'h7);
  localparam logic [PAGE_W-1:0] KEEP1   = ~PAGE_W'(1'b1);
  localparam bit                HI_EN   = (PAGE_W > BASE_W);

  logic [PAGE_W-1:0] pg_q  [4][2];
  logic              ram_q [4][2];
  logic              dos_q [4][2];

  logic [1:0]        wsel;
  logic [PAGE_W-1:0] cur_pg;
  logic              cur_ram, cur_dos;
  logic [7:0]        zd_n;
  logic [PAGE_W-1:0] page_c;
  logic              romnram_c;
  logic              fetch_c;
  rd_fmt_t           rd_c;
  logic              m1_n_q, mreq_n_d;

  wire unused_za = &{1'b0, za[10:0]};

  assign wsel    = za[15:14];
  assign cur_pg  = pg_q[wsel][map_sel];
  assign cur_ram = ram_q[wsel][map_sel];
  assign cur_dos = dos_q[wsel][map_sel];
  assign zd_n    = ~zd;

  // Reset page per window/map: W0 ROM maps, W1..W3 RAM 5/2/0
  function automatic logic [PAGE_W-1:0] rst_pg(input logic [1:0] w, input logic m);
    case (w)
      2'd0:    rst_pg = m ? (HI_MASK | PAGE_W'(PG_BAS48)) : (HI_MASK | PAGE_W'(PG_BAS128));
      2'd1:    rst_pg = PAGE_W'(PG_RAM5);
      2'd2:    rst_pg = PAGE_W'(PG_RAM2);
      default: rst_pg = PAGE_W'(PG_RAM0);
    endcase
  endfunction

  // Page register file: xxF7 (za[11]=1) / x7F7 (za[11]=0) and high-bit writes
  always_ff @(posedge fclk or negedge arst_n) begin
    if (!arst_n) begin
      for (int w = 0; w < 4; w++) begin
        for (int m = 0; m < 2; m++) begin
          pg_q[w][m]  <= rst_pg(2'(w), 1'(m));
          ram_q[w][m] <= (w != 0);
          dos_q[w][m] <= (w == 0) || (w == 3);
        end
      end
    end else if (f7_wr) begin
      if (za[11]) begin
        pg_q[wsel][map_sel]  <= ~PAGE_W'(zd[5:0]);
        ram_q[wsel][map_sel] <= zd[6];
        dos_q[wsel][map_sel] <= zd[7];
      end else begin
        pg_q[wsel][map_sel]  <= (cur_pg & HI_MASK) | PAGE_W'(zd_n);
        ram_q[wsel][map_sel] <= 1'b1;
      end
    end else if (hi_wr && HI_EN) begin
      pg_q[wsel][map_sel] <= (cur_pg & LO_MASK) | (PAGE_W'(zd_n) << BASE_W);
    end
  end

  // Lookup priority: service ROM, forced RAM0, then 7FFD-merged pages
  always_comb begin
    page_c    = cur_pg;
    romnram_c = ~cur_ram;
    if (pager_off) begin
      page_c    = '1;
      romnram_c = 1'b1;
    end else if (ram0_0 && (wsel == 2'd0)) begin
      page_c    = '0;
      romnram_c = 1'b0;
    end else if (cur_dos && cur_ram && p1m_on) begin
      page_c = (cur_pg & KEEP6) | PAGE_W'(p7_page);
    end else if (cur_dos && cur_ram) begin
      page_c = (cur_pg & KEEP3) | PAGE_W'(p7_page[2:0]);
    end else if (cur_dos) begin
      page_c = (cur_pg & KEEP1) | PAGE_W'(dos);
    end
  end

  assign rd_c = '{dos7ffd: dos_q[rd_win][map_sel],
                  ramnrom: ram_q[rd_win][map_sel],
                  pg_n:    ~pg_q[rd_win][map_sel][5:0]};

  // First cycle of an opcode fetch: mreq_n just fell while M1 is low
  assign fetch_c = zneg && !m1_n_q && !mreq_n && mreq_n_d;

  // Registered outputs and Z80 strobe sampling
  always_ff @(posedge fclk or negedge arst_n) begin
    if (!arst_n) begin
      page         <= '0;
      romnram      <= 1'b1;
      rd_data      <= '0;
      dos_turn_on  <= 1'b0;
      dos_turn_off <= 1'b0;
      m1_n_q       <= 1'b1;
      mreq_n_d     <= 1'b1;
    end else begin
      page         <= page_c;
      romnram      <= romnram_c;
      rd_data      <= rd_c;
      dos_turn_on  <= fetch_c && (wsel == 2'd0) && (za[13:8] == DOS_HI) && map_sel
                      && dos_q[0][1] && !ram_q[0][1];
      dos_turn_off <= fetch_c && cur_ram;
      if (zpos) m1_n_q <= m1_n;
      if (zneg) mreq_n_d <= mreq_n;
    end
  end

  atm_stall_fsm #(.STALL_LEN(STALL_LEN)) u_stall (
    .fclk       (fclk),
    .arst_n     (arst_n),
    .trig       (dos_turn_on),
    .zclk_stall (zclk_stall)
  );

endmodule
